// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting path.
// Holds the set-mode state encoding, the select_time field codes, and
// small helpers used by time_set_ctrl and the display logic.
package clock_pkg;

  // Each set state's encoding equals the select_time code of the field it edits.
  typedef enum logic [1:0] {
    ST_SET_HOUR = 2'd0,
    ST_SET_MIN  = 2'd1,
    ST_SET_SEC  = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  localparam logic [1:0] SEL_HOUR = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_SEC  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Mode-button order: RUN -> HOUR -> MIN -> SEC -> RUN.
  function automatic state_t next_mode(input state_t s);
    state_t n;
    case (s)
      ST_RUN:      n = ST_SET_HOUR;
      ST_SET_HOUR: n = ST_SET_MIN;
      ST_SET_MIN:  n = ST_SET_SEC;
      ST_SET_SEC:  n = ST_RUN;
      default:     n = ST_RUN;
    endcase
    return n;
  endfunction

  // Field code shown to the display for a given state.
  function automatic logic [1:0] sel_code(input state_t s);
    logic [1:0] c;
    case (s)
      ST_SET_HOUR: c = SEL_HOUR;
      ST_SET_MIN:  c = SEL_MIN;
      ST_SET_SEC:  c = SEL_SEC;
      ST_RUN:      c = SEL_NONE;
      default:     c = SEL_NONE;
    endcase
    return c;
  endfunction

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector plus hold-to-repeat generator for one button.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   btn       - debounced, synchronous button level
//   en        - repeat allowed this cycle (low clears and disarms)
//   btn_edge  - combinational rising edge of btn
//   fire      - combinational: a pulse is being launched this cycle
//   pulse     - registered one-cycle increment strobe
// Only a fresh edge while enabled arms the repeat, so a button already held
// when en rises never fires until it is released and pressed again.
module btn_repeat
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 32'd50_000_000,
  parameter int unsigned REPEAT_PERIOD = 32'd20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic en,
  output logic btn_edge,
  output logic fire,
  output logic pulse
);

  logic        prev_r;
  logic        live_r;   // low for the first cycle after reset: masks held buttons
  logic        armed_r;
  logic        rep_r;    // 0: waiting out the initial delay, 1: periodic phase
  logic [31:0] cnt_r;    // cycles since the last pulse, 1 on the cycle after it
  logic        pulse_r;

  logic        armed_s;
  logic        rep_s;
  logic [31:0] cnt_s;
  logic [31:0] limit_s;

  // Edge detection and next hold-counter / pulse decision.
  always_comb begin
    btn_edge = btn & ~prev_r & live_r;
    limit_s  = rep_r ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);
    fire     = 1'b0;
    armed_s  = armed_r;
    rep_s    = rep_r;
    cnt_s    = cnt_r;
    if (!btn || !en) begin
      armed_s = 1'b0;
      rep_s   = 1'b0;
      cnt_s   = 32'd0;
    end else if (btn_edge) begin
      fire    = 1'b1;
      armed_s = 1'b1;
      rep_s   = 1'b0;
      cnt_s   = 32'd1;
    end else if (armed_r) begin
      if (cnt_r == limit_s) begin
        fire  = 1'b1;
        rep_s = 1'b1;
        cnt_s = 32'd1;
      end else begin
        cnt_s = sat_inc(cnt_r);
      end
    end else begin
      cnt_s = 32'd0;
    end
  end

  // Button history, repeat state and registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r  <= 1'b0;
      live_r  <= 1'b0;
      armed_r <= 1'b0;
      rep_r   <= 1'b0;
      cnt_r   <= 32'd0;
      pulse_r <= 1'b0;
    end else begin
      prev_r  <= btn;
      live_r  <= 1'b1;
      armed_r <= armed_s;
      rep_r   <= rep_s;
      cnt_r   <= cnt_s;
      pulse_r <= fire;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC on
// mode presses, emits increment strobes (with hold auto-repeat), drives a
// blink enable for the edited field and drops back to RUN after idling.
// Ports:
//   clk_100MHz  - clock
//   rst_time    - synchronous active-high reset
//   btn_mode    - mode button level
//   btn_inc     - increment button level
//   change      - high in any set state
//   select_time - field under edit (0 hour, 1 min, 2 sec, 3 none)
//   inc_pulse   - one-cycle increment strobe
//   blink       - blink enable for the selected field
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 32'd50_000_000,
  parameter int unsigned REPEAT_PERIOD = 32'd20_000_000,
  parameter int unsigned TIMEOUT       = 32'd1_000_000_000,
  parameter int unsigned BLINK_HALF    = 32'd25_000_000
) (
  input  logic       clk_100MHz,
  input  logic       rst_time,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       change,
  output logic [1:0] select_time,
  output logic       inc_pulse,
  output logic       blink
);

  state_t      state_r;
  logic        mode_prev_r;
  logic        live_r;
  logic [31:0] idle_r;
  logic [31:0] blink_cnt_r;
  logic        blink_r;
  logic        change_r;
  logic [1:0]  select_r;

  state_t      state_s;
  logic        mode_edge_s;
  logic        timeout_s;
  logic        state_chg_s;
  logic        rep_en_s;
  logic        inc_edge_s;
  logic        fire_s;
  logic [31:0] idle_s;
  logic [31:0] blink_cnt_s;
  logic        blink_s;

  // Mode-edge detection and next-state selection; a mode edge wins over timeout.
  always_comb begin
    mode_edge_s = btn_mode & ~mode_prev_r & live_r;
    timeout_s   = (state_r != ST_RUN) && (idle_r == 32'(TIMEOUT));
    if (mode_edge_s) begin
      state_s = next_mode(state_r);
    end else if (timeout_s) begin
      state_s = ST_RUN;
    end else begin
      state_s = state_r;
    end
    state_chg_s = (state_s != state_r);
    // Increments only count in a stable set state.
    rep_en_s    = (state_r != ST_RUN) && !state_chg_s;
  end

  btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_inc (
    .clk     (clk_100MHz),
    .rst     (rst_time),
    .btn     (btn_inc),
    .en      (rep_en_s),
    .btn_edge(inc_edge_s),
    .fire    (fire_s),
    .pulse   (inc_pulse)
  );

  // Idle timeout counter and blink phase, both restarted by state changes.
  always_comb begin
    idle_s      = idle_r;
    blink_cnt_s = blink_cnt_r;
    blink_s     = blink_r;
    if (state_s == ST_RUN || state_chg_s) begin
      idle_s = 32'd0;
    end else if (mode_edge_s || inc_edge_s || fire_s) begin
      idle_s = 32'd0;
    end else begin
      idle_s = sat_inc(idle_r);
    end
    if (state_s == ST_RUN) begin
      blink_s     = 1'b0;
      blink_cnt_s = 32'd0;
    end else if (state_chg_s || fire_s) begin
      blink_s     = 1'b1;
      blink_cnt_s = 32'd1;
    end else if (blink_cnt_r == 32'(BLINK_HALF)) begin
      blink_s     = ~blink_r;
      blink_cnt_s = 32'd1;
    end else begin
      blink_s     = blink_r;
      blink_cnt_s = sat_inc(blink_cnt_r);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (rst_time) begin
      state_r     <= ST_RUN;
      mode_prev_r <= 1'b0;
      live_r      <= 1'b0;
      idle_r      <= 32'd0;
      blink_cnt_r <= 32'd0;
      blink_r     <= 1'b0;
      change_r    <= 1'b0;
      select_r    <= SEL_NONE;
    end else begin
      state_r     <= state_s;
      mode_prev_r <= btn_mode;
      live_r      <= 1'b1;
      idle_r      <= idle_s;
      blink_cnt_r <= blink_cnt_s;
      blink_r     <= blink_s;
      change_r    <= (state_s != ST_RUN);
      select_r    <= sel_code(state_s);
    end
  end

  assign change      = change_r;
  assign select_time = select_r;
  assign blink       = blink_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl with small timing parameters.
module tb_time_set_ctrl;

  localparam int RD = 4;
  localparam int RP = 2;
  localparam int TO = 20;
  localparam int BH = 3;

  logic       clk = 1'b0;
  logic       rst_time = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       change;
  logic [1:0] select_time;
  logic       inc_pulse;
  logic       blink;

  int checks = 0;
  int errors = 0;

  // Reference model: mode index 0=RUN, 1=HOUR, 2=MIN, 3=SEC.
  int m_state = 0;
  int m_idle = 0;
  int m_hold = 0;
  int m_phase = 0;
  bit m_armed = 0;
  bit m_prev_mode = 0;
  bit m_prev_inc = 0;
  bit m_live = 0;
  bit e_pulse = 0;
  bit e_blink = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .TIMEOUT      (TO),
    .BLINK_HALF   (BH)
  ) dut (
    .clk_100MHz (clk),
    .rst_time   (rst_time),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .change     (change),
    .select_time(select_time),
    .inc_pulse  (inc_pulse),
    .blink      (blink)
  );

  function automatic logic [4:0] exp_vec();
    logic [1:0] sel;
    sel = (m_state == 0) ? 2'd3 : 2'(m_state - 1);
    return {(m_state != 0), sel, e_pulse, e_blink};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {change, select_time, inc_pulse, blink};
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    bit me;
    bit ie;
    bit chg;
    int ns;
    if (rst_time) begin
      m_state = 0; m_prev_mode = 0; m_prev_inc = 0; m_live = 0;
      m_armed = 0; m_hold = 0; m_idle = 0; m_phase = 0;
      e_pulse = 0; e_blink = 0;
    end else begin
      me = btn_mode && !m_prev_mode && m_live;
      ie = btn_inc && !m_prev_inc && m_live;
      if (me) ns = (m_state + 1) % 4;
      else if (m_state != 0 && m_idle == TO) ns = 0;
      else ns = m_state;
      chg = (ns != m_state);
      e_pulse = 0;
      if (!btn_inc || m_state == 0 || chg) begin
        m_armed = 0; m_hold = 0;
      end else if (ie) begin
        m_armed = 1; m_hold = 0; e_pulse = 1;
      end else if (m_armed) begin
        m_hold++;
        if (m_hold >= RD && ((m_hold - RD) % RP) == 0) e_pulse = 1;
      end
      if (ns == 0 || chg || me || ie || e_pulse) m_idle = 0;
      else m_idle++;
      if (ns == 0) begin
        m_phase = 0; e_blink = 0;
      end else begin
        if (chg || e_pulse) m_phase = 0;
        else m_phase++;
        e_blink = ((m_phase / BH) % 2) == 0;
      end
      m_prev_mode = btn_mode; m_prev_inc = btn_inc; m_live = 1; m_state = ns;
    end
  endtask

  task automatic tick(input bit m, input bit i, input bit r);
    btn_mode = m; btn_inc = i; rst_time = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 1);
      checks++;
      if (dut_vec() !== 5'b0_11_0_0) begin
        errors++;
        $display("FAIL reset_vals: got %b want %b", dut_vec(), 5'b0_11_0_0);
      end
    end
    // Mode and inc held through reset release: no edge may be seen.
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 0);
      checks++;
      if (select_time !== 2'd3 || change !== 1'b0 || inc_pulse !== 1'b0) begin
        errors++;
        $display("FAIL held_thru_reset k%0d: got %b want %b", k, dut_vec(), 5'b0_11_0_0);
      end
    end
    tick(0, 0, 0);
  endtask

  task automatic test_mode_cycle();
    logic [1:0] sel_seq [4];
    logic       chg_seq [4];
    sel_seq = '{2'd0, 2'd1, 2'd2, 2'd3};
    chg_seq = '{1'b1, 1'b1, 1'b1, 1'b0};
    tick(0, 0, 1);
    tick(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 0);
      checks++;
      if (select_time !== sel_seq[k] || change !== chg_seq[k]) begin
        errors++;
        $display("FAIL mode_cycle k%0d: got sel=%0d chg=%b want sel=%0d chg=%b",
                 k, select_time, change, sel_seq[k], chg_seq[k]);
      end
      tick(0, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mode_cycle_model k%0d: got %b want %b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_repeat();
    logic [11:0] mask;
    mask = 12'h551;  // pulses on held ticks 1, 5, 7, 9, 11
    tick(0, 0, 1); tick(0, 0, 0);
    tick(1, 0, 0); tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
    checks++;
    if (select_time !== 2'd1) begin
      errors++;
      $display("FAIL repeat_setup: got sel=%0d want sel=1", select_time);
    end
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, 0);
      checks++;
      if (inc_pulse !== mask[i] || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL repeat tick%0d: got %b want pulse=%b model=%b", i + 1, dut_vec(), mask[i], exp_vec());
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0);
      checks++;
      if (inc_pulse !== 1'b0) begin
        errors++;
        $display("FAIL repeat_release tick%0d: got pulse=%b want pulse=0", i, inc_pulse);
      end
    end
  endtask

  task automatic test_simultaneous();
    tick(0, 0, 1); tick(0, 0, 0);
    tick(1, 0, 0); tick(0, 0, 0);
    tick(1, 1, 0);
    checks++;
    if (select_time !== 2'd1 || inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL simult_edge: got sel=%0d pulse=%b want sel=1 pulse=0", select_time, inc_pulse);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0);
      checks++;
      if (inc_pulse !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simult_hold tick%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    tick(0, 0, 0);
    tick(0, 1, 0);
    checks++;
    if (inc_pulse !== 1'b1 || select_time !== 2'd1) begin
      errors++;
      $display("FAIL simult_repress: got sel=%0d pulse=%b want sel=1 pulse=1", select_time, inc_pulse);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_blink_timeout();
    logic exp_b;
    logic [1:0] exp_s;
    tick(0, 0, 1); tick(0, 0, 0);
    tick(1, 0, 0); tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
    for (int k = 0; k < 24; k++) begin
      if (k == 0) tick(1, 0, 0);  // enters SET_SEC
      else tick(0, 0, 0);
      exp_b = (k <= TO) ? (((k / BH) % 2) == 0) : 1'b0;
      exp_s = (k <= TO) ? 2'd2 : 2'd3;
      checks++;
      if (blink !== exp_b || select_time !== exp_s || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL blink_timeout k%0d: got blink=%b sel=%0d want blink=%b sel=%0d",
                 k, blink, select_time, exp_b, exp_s);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    tick(0, 0, 1); tick(0, 0, 0);
    tick(1, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midrep_hold tick%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    // Reset lands exactly where the next repeat pulse would have fired.
    tick(0, 1, 1);
    checks++;
    if (dut_vec() !== 5'b0_11_0_0) begin
      errors++;
      $display("FAIL midrep_reset: got %b want %b", dut_vec(), 5'b0_11_0_0);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 0);
      checks++;
      if (inc_pulse !== 1'b0 || select_time !== 2'd3) begin
        errors++;
        $display("FAIL midrep_after tick%0d: got sel=%0d pulse=%b want sel=3 pulse=0", i, select_time, inc_pulse);
      end
    end
    tick(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (select_time !== 2'd0 || inc_pulse !== 1'b0) begin
        errors++;
        $display("FAIL held_into_set tick%0d: got sel=%0d pulse=%b want sel=0 pulse=0", i, select_time, inc_pulse);
      end
      tick(0, 1, 0);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_run_ignore();
    tick(0, 0, 1); tick(0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick(0, (i != 10), 0);  // hold, release once, press again
      checks++;
      if (inc_pulse !== 1'b0 || select_time !== 2'd3 || change !== 1'b0) begin
        errors++;
        $display("FAIL run_ignore tick%0d: got %b want %b", i, dut_vec(), 5'b0_11_0_0);
      end
    end
    tick(0, 0, 0);
  endtask

  task automatic test_random();
    bit inc_lvl;
    bit mode_lvl;
    int rate;
    inc_lvl = 0;
    mode_lvl = 0;
    tick(0, 0, 1); tick(0, 0, 0);
    for (int seg = 0; seg < 50; seg++) begin
      rate = $urandom_range(0, 3);
      for (int c = 0; c < 40; c++) begin
        mode_lvl = (rate != 0) && ($urandom_range(0, 15) < rate);
        if ($urandom_range(0, 5) == 0) inc_lvl = ~inc_lvl;
        tick(mode_lvl, inc_lvl, ($urandom_range(0, 399) == 0));
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random seg%0d c%0d: got %b want %b", seg, c, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_repeat();
    test_simultaneous();
    test_blink_timeout();
    test_reset_mid_repeat();
    test_run_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
